// File: rtl/aes_pkg.sv
// Shared AES types, state encoding and GF(2^8) helpers used by the encryptor and decryptor.
package aes_pkg;

    typedef logic [127:0] aes_block_t;
    typedef logic [31:0]  aes_word_t;
    typedef logic [7:0]   byte_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KEXP = 2'd1,
        ST_DEC  = 2'd2,
        ST_DONE = 2'd3
    } aes_state_t;

    localparam byte_t RCON_FIRST = 8'h01;
    localparam byte_t RCON_LAST  = 8'h36;

    function automatic byte_t xtime(byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Exact inverse of xtime, used to walk rcon backwards during decryption.
    function automatic byte_t inv_xtime(byte_t r);
        return r[0] ? (((r ^ 8'h1b) >> 1) | 8'h80) : (r >> 1);
    endfunction

    function automatic byte_t rotl8(byte_t b, int unsigned n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic byte_t gf_mul(byte_t a, byte_t b);
        byte_t p;
        byte_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic byte_t gf_inv(byte_t x);
        byte_t x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
module aes_inv_round
    import aes_pkg::*;
(
    input  aes_block_t state,
    input  aes_block_t round_key,
    input  logic       last,
    output aes_block_t result
);
    function automatic byte_t inv_sbox(byte_t b);
        return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
    endfunction

    function automatic aes_word_t inv_mix_col(aes_word_t w);
        byte_t a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    aes_block_t subbed;
    aes_block_t added;
    aes_block_t mixed;

    // Byte 4c+r sits at [127-8(4c+r)]; row r is rotated right by r columns.
    always_comb begin
        subbed = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                subbed[127 - 8*(4*c + r) -: 8] =
                    inv_sbox(state[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]);
            end
        end
    end

    assign added = subbed ^ round_key;

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32*c -: 32] = inv_mix_col(added[127 - 32*c -: 32]);
        end
    end

    assign result = last ? added : mixed;

endmodule

// File: rtl/aes_key_scheduling.sv
// One forward AES-128 key-expansion step: round key r -> round key r+1.
module aes_key_scheduling
    import aes_pkg::*;
(
    input  aes_block_t key,
    input  byte_t      rcon,
    output aes_block_t next_key
);
    aes_word_t w0, w1, w2, w3, rot, sub, n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sub
        aes_sbox u_sbox (.a(rot[8*i +: 8]), .s(sub[8*i +: 8]));
    end

    assign n0 = w0 ^ sub ^ {rcon, 24'h0};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box: field inverse followed by the affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  byte_t a,
    output byte_t s
);
    byte_t v;

    assign v = gf_inv(a);
    assign s = v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;

endmodule

// File: rtl/aes_dec.sv
// Iterative AES-128 decryptor: 10 forward key-expansion cycles, then 10 inverse rounds with the schedule unwound.
module aes_dec
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         data_valid_in,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic         ready_out,
    output logic [127:0] res_dec_out,
    output logic         res_valid_out
);
    localparam logic [3:0] LAST_CNT = 4'd9;

    aes_state_t state;
    logic [3:0] cnt;
    aes_block_t data_q, key_q, res_q, fwd_key, inv_key, round_out;
    byte_t      rcon_q;

    aes_key_scheduling u_fwd (.key(key_q), .rcon(rcon_q), .next_key(fwd_key));

    // Backward key step: recover w1..w3 by pairwise XOR, then undo the w0 update.
    aes_word_t w0, w1, w2, w3, n3, rot, sub;
    assign {w0, w1, w2, w3} = key_q;
    assign n3  = w3 ^ w2;
    assign rot = {n3[23:0], n3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_inv_sub
        aes_sbox u_sbox (.a(rot[8*i +: 8]), .s(sub[8*i +: 8]));
    end

    assign inv_key = {w0 ^ sub ^ {rcon_q, 24'h0}, w1 ^ w0, w2 ^ w1, n3};

    aes_inv_round u_round (
        .state    (data_q),
        .round_key(inv_key),
        .last     (cnt == 4'd0),
        .result   (round_out)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            data_q <= '0;
            key_q  <= '0;
            rcon_q <= '0;
            res_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (data_valid_in) begin
                        data_q <= data_in;
                        key_q  <= key_in;
                        rcon_q <= RCON_FIRST;
                        cnt    <= '0;
                        state  <= ST_KEXP;
                    end
                end
                ST_KEXP: begin
                    key_q <= fwd_key;
                    if (cnt == LAST_CNT) begin
                        data_q <= data_q ^ fwd_key;
                        rcon_q <= RCON_LAST;
                        state  <= ST_DEC;
                    end else begin
                        rcon_q <= xtime(rcon_q);
                        cnt    <= cnt + 4'd1;
                    end
                end
                ST_DEC: begin
                    key_q  <= inv_key;
                    data_q <= round_out;
                    rcon_q <= inv_xtime(rcon_q);
                    if (cnt == 4'd0) begin
                        res_q <= round_out;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ready_out     = (state == ST_IDLE);
    assign res_valid_out = (state == ST_DONE);
    assign res_dec_out   = res_q;

endmodule

// File: tb/tb_aes_dec.sv
// Directed-vector bench for aes_dec: known-answer blocks, latency, busy input, back-to-back and async reset.
module tb_aes_dec;
    logic         clk;
    logic         resetn;
    logic         data_valid_in;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic         ready_out;
    logic [127:0] res_dec_out;
    logic         res_valid_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic [7:0] rcon_exp [10] = '{8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    aes_dec dut (
        .clk          (clk),
        .resetn       (resetn),
        .data_valid_in(data_valid_in),
        .data_in      (data_in),
        .key_in       (key_in),
        .ready_out    (ready_out),
        .res_dec_out  (res_dec_out),
        .res_valid_out(res_valid_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, ready_out, 1);
        check({tag, "_valid"}, res_valid_out, 0);
        check({tag, "_res"}, res_dec_out, 0);
    endtask

    // driver: one-cycle valid pulse; returns 1ns after the acceptance edge T
    task automatic send(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt);
        @(negedge clk);
        data_valid_in = 1'b1;
        data_in       = ct;
        key_in        = key;
        exp_q.push_back(pt);
        @(posedge clk);
        #1;
        data_valid_in = 1'b0;
    endtask

    // mode 1: check rk10 after T+10; mode 2: trace rcon over T+10..T+19
    task automatic wait_result(input string tag, input int mode);
        logic [127:0] exp;
        int lat;
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) check({tag, "_busy"}, ready_out, 0);
            if (mode == 1 && i == 10) check({tag, "_rk10"}, dut.key_q, B_RK10);
            if (mode == 2 && i >= 10 && i <= 19)
                check($sformatf("%s_rcon%0d", tag, i), dut.rcon_q, rcon_exp[i-10]);
            if (res_valid_out) begin
                lat  = i;
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_strobe"}, seen, 1);
        if (seen) begin
            exp = exp_q.pop_front();
            check({tag, "_latency"}, lat, 20);
            check({tag, "_pt"}, res_dec_out, exp);
            @(posedge clk);
            #1;
            check({tag, "_one_strobe"}, res_valid_out, 0);
            check({tag, "_ready_back"}, ready_out, 1);
            check({tag, "_hold"}, res_dec_out, exp);
        end
    endtask

    task automatic reset_mid_block(input string tag, input int edges_after_t);
        send(C1_KEY, C1_CT, C1_PT);
        repeat (edges_after_t - 1) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check_reset_outputs(tag);
        void'(exp_q.pop_back());
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (res_valid_out) check({tag, "_no_strobe"}, res_valid_out, 0);
        end
    endtask

    initial begin
        int seen;
        resetn        = 1'b0;
        data_valid_in = 1'b0;
        data_in       = '0;
        key_in        = '0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        send(C1_KEY, C1_CT, C1_PT);
        wait_result("c1", 2);
        send(B_KEY, B_CT, B_PT);
        wait_result("fips_b", 1);
        send('0, Z_CT, '0);
        wait_result("zero", 0);

        // busy input: valid held high with changing data, then back-to-back at T+22
        @(negedge clk);
        data_valid_in = 1'b1;
        data_in       = C1_CT;
        key_in        = C1_KEY;
        @(posedge clk);
        #1;
        seen = 0;
        for (int i = 1; i <= 21; i++) begin
            data_in = {$urandom, $urandom, $urandom, $urandom};
            key_in  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            if (i == 10) check("busy_not_ready", ready_out, 0);
            if (res_valid_out) begin
                seen++;
                check("busy_latency", i, 20);
                check("busy_pt", res_dec_out, C1_PT);
            end
        end
        check("busy_strobes", seen, 1);
        check("busy_ready_t21", ready_out, 1);
        data_in = B_CT;
        key_in  = B_KEY;
        exp_q.push_back(B_PT);
        @(posedge clk);
        #1;
        data_valid_in = 1'b0;
        check("b2b_accept_t22", ready_out, 0);
        wait_result("b2b", 0);

        reset_mid_block("rst_t7", 7);
        reset_mid_block("rst_t15", 15);
        send(C1_KEY, C1_CT, C1_PT);
        wait_result("after_rst", 0);

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_dec.md
# aes_dec

AES-128 decryption engine: the inverse of the existing iterative `aes` encryptor, consuming its ciphertext and key and returning plaintext. Iterative, one round per cycle. A forward key-expansion phase derives round key 10 from the cipher key; the inverse cipher then runs while the key schedule is unwound backwards. Sits beside `aes` on the same data/key bus style, with an added ready handshake because the core is busy for 21 cycles.

## Interface
Parameters: none. AES-128 only; Nr = 10 is fixed.

- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `data_valid_in`  in  1  ciphertext/key valid; accepted only when `ready_out` = 1.
- `data_in`  in  128  ciphertext; FIPS-197 byte 0 at [127:120].
- `key_in`  in  128  cipher key, the same key given to `aes`; byte 0 at [127:120].
- `ready_out`  out  1  high only in IDLE.
- `res_dec_out`  out  128  plaintext; valid while `res_valid_out` = 1, otherwise holds the last value.
- `res_valid_out`  out  1  one-cycle result strobe.

## Operation
- States:
  - IDLE
  - KEXP: 10 cycles, counter 0..9.
  - DEC: 10 cycles, counter 9..0.
  - DONE: 1 cycle.
- **IDLE.** On `data_valid_in` = 1:
  - `data_q` <= `data_in`, `key_q` <= `key_in`, `rcon_q` <= 8'h01.
  - Go to KEXP with counter 0.
- **KEXP.** Each cycle: `key_q` <= forward_step(`key_q`, `rcon_q`); `rcon_q` <= xtime(`rcon_q`).
  - Use the existing `aes_key_scheduling` for forward_step.
  - On counter 9, `key_q` becomes rk10, and in the same edge `data_q` <= `data_q` ^ rk10 (the forward_step output).
  - On that edge `rcon_q` <= 8'h36, overriding xtime. Go to DEC with counter 9.
- **DEC round r = 9..1.** Each cycle:
  - `key_q` <= inv_step(`key_q`, `rcon_q`) = rk_r.
  - `data_q` <= InvMixColumns(InvSubBytes(InvShiftRows(`data_q`)) ^ rk_r).
  - `rcon_q` <= inv_xtime(`rcon_q`).
- **DEC final (counter 0).** `data_q` <= InvSubBytes(InvShiftRows(`data_q`)) ^ rk0, where rk0 = inv_step(`key_q`, 8'h01). Go to DONE.
- **inv_step** from words w0..w3, w0 at [127:96]:
  - w3' = w3^w2; w2' = w2^w1; w1' = w1^w0.
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {rcon, 24'h0}.
- **inv_xtime(r)** = r[0] ? (((r ^ 8'h1b) >> 1) | 8'h80) : (r >> 1). Sequence: 36,1b,80,40,20,10,08,04,02,01.
- **DONE.** `res_valid_out` = 1 and `res_dec_out` = `data_q`. Go to IDLE.
- `data_valid_in` outside IDLE is ignored; no queueing and no error flag.
- Simultaneous DONE and `data_valid_in`: the input is ignored because `ready_out` = 0 in DONE. A new block is accepted from the next IDLE cycle.
- The key is re-expanded for every block; there is no key caching.

## Timing
- Reset (async assert, any state): FSM to IDLE; counter, `data_q`, `key_q`, `rcon_q` to 0.
  - Outputs during reset: `ready_out` = 1, `res_valid_out` = 0, `res_dec_out` = 0.
  - Mid-operation reset aborts the block; no result strobe follows.
- Acceptance edge T: the edge where `ready_out` & `data_valid_in` are both 1.
- Edges T+1..T+10: KEXP.
- Edges T+11..T+19: DEC rounds 9..1.
- Edge T+20: final round.
- DONE: `res_valid_out` high from T+20 to T+21.
- `ready_out` returns high after edge T+21.
- Throughput: one block per 21 cycles, minimum gap to the next acceptance edge T+22.
- Outputs are registered-state decodes only; no combinational path from inputs to outputs.

## Structure
- Shared package `aes_pkg` holds:
  - `aes_block_t`, `aes_word_t`, `byte_t`
  - the state enum
  - RCON_FIRST = 8'h01, RCON_LAST = 8'h36
  - functions xtime and inv_xtime
- Reused as-is: `aes_key_scheduling` (forward phase) and `aes_sbox` (SubWord in inv_step).
- New sub-module `aes_inv_round`: combinational InvShiftRows, then InvSubBytes (16 inverse S-boxes), AddRoundKey, then InvMixColumns. Inputs: state, round key, `last`.
- Inverse S-box and InvMixColumns word helpers live inside `aes_inv_round`.

## Test plan
- **FIPS-197 C.1.** key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, strobe exactly 20 cycles after acceptance.
- **FIPS-197 B.** key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734. Internal rk10 must equal d014f9a8c9ee2589e13f0cc8b6630ca6.
- **Loopback.** 1000 random key/pt pairs through `aes`, then `aes_dec` -> original pt every time, one strobe per block.
- **Busy input.** `data_valid_in` held high with changing data during KEXP/DEC/DONE -> ignored, result matches the accepted block. Back-to-back acceptance occurs at T+22.
- **Reset.** Assert `resetn` low at cycle T+7 and T+15, asynchronously mid-cycle -> immediate `ready_out` = 1, `res_valid_out` = 0, `res_dec_out` = 0. The next C.1 block decodes correctly.
- **rcon trace.** Check `rcon_q` sequence 36,1b,80,...,01 across DEC.
